// File: rtl/rvh_noc_vc_credit_tracker.sv
// Downstream VC credit tracker and VC selector for one mesh-router output port.
// Latency: counters update one edge after consume/return; selection is combinational from the counters.
// Backpressure: none. Offers VCs only while credit > 0 and flags consume-at-zero / return-at-full as errors.
//
// Optional feature macro: CREDIT_RET_BYPASS_EN
//   defined   - a credit returned this cycle makes its VC selectable in the same cycle
//               (selection sees cnt+ret; credit_cnt_o / all_credit_full_o stay registered)
//   undefined - a returned credit becomes selectable the following cycle (shorter path)
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   consume_vld_i/_vc_id_i a flit leaves on this output into downstream VC consume_vc_id_i
//   credit_ret_vld_i/_vc_id_i  downstream returned one credit for VC credit_ret_vc_id_i
//   common_vld_o/_vc_id_o  round-robin chosen common VC with credit (id held when none)
//   rt_vld_o/_vc_id_o      real-time VC (index VC_NUM-1) has credit; only if RT_VC_NUM=1
//   credit_cnt_o           packed per-VC credit counters, VC0 in the LSBs
//   all_credit_full_o      every counter at VC_DEPTH (downstream fully drained)
//   err_o                  sticky protocol error, cleared only by rst

module rvh_noc_vc_credit_tracker #(
  parameter int VC_NUM    = 5,
  parameter int VC_DEPTH  = 2,
  parameter int RT_VC_NUM = 0,
  parameter int VC_ID_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int CNT_W     = $clog2(VC_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      consume_vld_i,
  input  logic [VC_ID_W-1:0]        consume_vc_id_i,
  input  logic                      credit_ret_vld_i,
  input  logic [VC_ID_W-1:0]        credit_ret_vc_id_i,
  output logic                      common_vld_o,
  output logic [VC_ID_W-1:0]        common_vc_id_o,
  output logic                      rt_vld_o,
  output logic [VC_ID_W-1:0]        rt_vc_id_o,
  output logic [VC_NUM*CNT_W-1:0]   credit_cnt_o,
  output logic                      all_credit_full_o,
  output logic                      err_o
);

  // Common VCs occupy indices 0..COM_NUM-1; the RT VC, when present, is the last index.
  localparam int COM_NUM = VC_NUM - RT_VC_NUM;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(VC_DEPTH);

  logic [CNT_W-1:0]   cnt_q [VC_NUM];
  logic [CNT_W-1:0]   cnt_d [VC_NUM];
  logic [VC_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [VC_ID_W-1:0] last_id_q;
  logic               err_q, err_d;

  logic [VC_NUM-1:0]  cons_hit;
  logic [VC_NUM-1:0]  ret_hit;
  logic               cons_oor;
  logic               ret_oor;
  logic [VC_NUM-1:0]  avail;
  logic               sel_found;
  logic [VC_ID_W-1:0] sel_id;

  // Decode the per-VC strobes; an id beyond VC_NUM-1 hits nothing and is an error.
  always_comb begin
    cons_hit = '0;
    ret_hit  = '0;
    cons_oor = consume_vld_i    && (int'(consume_vc_id_i)    >= VC_NUM);
    ret_oor  = credit_ret_vld_i && (int'(credit_ret_vc_id_i) >= VC_NUM);
    for (int v = 0; v < VC_NUM; v++) begin
      cons_hit[v] = consume_vld_i    && (int'(consume_vc_id_i)    == v);
      ret_hit[v]  = credit_ret_vld_i && (int'(credit_ret_vc_id_i) == v);
    end
  end

  // Counter next state. Consume+return on the same VC cancel out, even at 0 or full,
  // because the returned slot is immediately refilled by the new flit.
  always_comb begin
    err_d = err_q | cons_oor | ret_oor;
    for (int v = 0; v < VC_NUM; v++) begin
      cnt_d[v] = cnt_q[v];
      case ({cons_hit[v], ret_hit[v]})
        2'b10: begin
          if (cnt_q[v] == '0) err_d = 1'b1;
          else                cnt_d[v] = cnt_q[v] - 1'b1;
        end
        2'b01: begin
          if (cnt_q[v] == DEPTH_C) err_d = 1'b1;
          else                     cnt_d[v] = cnt_q[v] + 1'b1;
        end
        default: cnt_d[v] = cnt_q[v];
      endcase
    end
  end

  // Round-robin pointer moves just past the common VC that was consumed.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (consume_vld_i && (int'(consume_vc_id_i) < COM_NUM)) begin
      if (int'(consume_vc_id_i) == COM_NUM - 1) rr_ptr_d = '0;
      else                                      rr_ptr_d = consume_vc_id_i + 1'b1;
    end
  end

  // Per-VC availability seen by the selection logic.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
`ifdef CREDIT_RET_BYPASS_EN
      avail[v] = (cnt_q[v] != '0) || ret_hit[v];
`else
      avail[v] = (cnt_q[v] != '0);
`endif
    end
  end

  // Scan the common VCs starting at rr_ptr; the first with credit wins.
  // With nothing available the last offered id is held so downstream logic sees a stable id.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = last_id_q;
    for (int i = 0; i < COM_NUM; i++) begin
      int idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= COM_NUM) idx = idx - COM_NUM;
      if (!sel_found && avail[idx]) begin
        sel_found = 1'b1;
        sel_id    = VC_ID_W'(idx);
      end
    end
  end

  assign common_vld_o   = sel_found;
  assign common_vc_id_o = sel_id;

  generate
    if (RT_VC_NUM > 0) begin : g_rt
      assign rt_vld_o   = avail[VC_NUM-1];
      assign rt_vc_id_o = VC_ID_W'(VC_NUM - 1);
    end else begin : g_no_rt
      assign rt_vld_o   = 1'b0;
      assign rt_vc_id_o = '0;
    end
  endgenerate

  always_comb begin
    all_credit_full_o = 1'b1;
    for (int v = 0; v < VC_NUM; v++) begin
      credit_cnt_o[v*CNT_W +: CNT_W] = cnt_q[v];
      if (cnt_q[v] != DEPTH_C) all_credit_full_o = 1'b0;
    end
  end

  assign err_o = err_q;

  // Reset mid-traffic drops in-flight credits; neighbours are reset together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) cnt_q[v] <= DEPTH_C;
      rr_ptr_q  <= '0;
      last_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) cnt_q[v] <= cnt_d[v];
      rr_ptr_q  <= rr_ptr_d;
      last_id_q <= sel_id;
      err_q     <= err_d;
    end
  end

endmodule
